// File: rtl/mio_bus_responder_if.sv
// mio_bus_responder_if: bundles the CPU MIO request/response signals with the
// RAM and IO peripheral port signals of the MIO bus responder.
//   slave  : the responder (takes CPU requests and RAM/IO returns, drives the rest)
//   master : the environment (CPU, RAM and peripheral side)
interface mio_bus_responder_if #(
  parameter int unsigned RAM_AW = 12
);
  // CPU side
  logic              CPU_MIO;
  logic              mem_w;
  logic [31:0]       Addr_in;
  logic [31:0]       data_from_cpu;
  logic [31:0]       data_to_cpu;
  logic              MIO_ready;
  logic              busy;
  // RAM port
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  // IO port
  logic              io_sel;
  logic              io_we;
  logic [31:0]       io_addr;
  logic [31:0]       io_wdata;
  logic [31:0]       io_rdata;
  logic              io_ready;
  logic              bus_err;

  modport slave (
    input  CPU_MIO, mem_w, Addr_in, data_from_cpu, ram_rdata, io_rdata, io_ready,
    output data_to_cpu, MIO_ready, busy, ram_en, ram_we, ram_addr, ram_wdata,
           io_sel, io_we, io_addr, io_wdata, bus_err
  );

  modport master (
    output CPU_MIO, mem_w, Addr_in, data_from_cpu, ram_rdata, io_rdata, io_ready,
    input  data_to_cpu, MIO_ready, busy, ram_en, ram_we, ram_addr, ram_wdata,
           io_sel, io_we, io_addr, io_wdata, bus_err
  );
endinterface

// File: rtl/mio_bus_responder.sv
// mio_bus_responder: memory/IO responder for the multi-cycle CPU MIO interface.
// Accepts a request in IDLE, decodes RAM vs IO by Addr_in[31:28], runs a fixed
// wait sequence on the synchronous RAM port or a handshake on the IO port, and
// returns read data with a one-cycle MIO_ready pulse.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : mio_bus_responder_if.slave (CPU request/response, RAM port, IO port)
// Optional feature: define MIO_BUS_TIMEOUT_EN to bound IO waits to TIMEOUT
// cycles; a timeout completes with bus_err=1 and read data 32'hDEADBEEF.
module mio_bus_responder #(
  parameter int unsigned RAM_AW   = 12,
  parameter int unsigned RAM_WAIT = 1,
  parameter logic [3:0]  IO_NIB   = 4'hF,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  mio_bus_responder_if.slave        bus
);

  // One counter serves both the RAM wait sequence and the IO timeout.
  localparam int unsigned CNT_MAX = (RAM_WAIT > TIMEOUT) ? RAM_WAIT : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RAM_LAST = CNT_W'(RAM_WAIT);
`ifdef MIO_BUS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAM_WAIT,
    S_IO_WAIT,
    S_ACK
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       data_to_cpu_q, data_to_cpu_d;
  logic              mio_ready_q, mio_ready_d;
  logic              busy_q, busy_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              io_sel_q, io_sel_d;
  logic              io_we_q, io_we_d;
  logic [31:0]       io_addr_q, io_addr_d;
  logic [31:0]       io_wdata_q, io_wdata_d;
`ifdef MIO_BUS_TIMEOUT_EN
  logic              bus_err_q, bus_err_d;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      data_to_cpu_q <= '0;
      mio_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      io_sel_q      <= 1'b0;
      io_we_q       <= 1'b0;
      io_addr_q     <= '0;
      io_wdata_q    <= '0;
`ifdef MIO_BUS_TIMEOUT_EN
      bus_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      data_to_cpu_q <= data_to_cpu_d;
      mio_ready_q   <= mio_ready_d;
      busy_q        <= busy_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      io_sel_q      <= io_sel_d;
      io_we_q       <= io_we_d;
      io_addr_q     <= io_addr_d;
      io_wdata_q    <= io_wdata_d;
`ifdef MIO_BUS_TIMEOUT_EN
      bus_err_q     <= bus_err_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    data_to_cpu_d = data_to_cpu_q;
    mio_ready_d   = 1'b0;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    io_sel_d      = io_sel_q;
    io_we_d       = io_we_q;
    io_addr_d     = io_addr_q;
    io_wdata_d    = io_wdata_q;
`ifdef MIO_BUS_TIMEOUT_EN
    bus_err_d     = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.CPU_MIO) begin
          we_d  = bus.mem_w;
          cnt_d = '0;
          if (bus.Addr_in[31:28] == IO_NIB) begin
            state_d    = S_IO_WAIT;
            io_sel_d   = 1'b1;
            io_we_d    = bus.mem_w;
            io_addr_d  = bus.Addr_in;
            io_wdata_d = bus.data_from_cpu;
          end else begin
            // RAM strobe is a single-cycle pulse issued on entry to RAM_WAIT
            state_d     = S_RAM_WAIT;
            ram_en_d    = 1'b1;
            ram_we_d    = bus.mem_w;
            ram_addr_d  = bus.Addr_in[RAM_AW+1:2];
            ram_wdata_d = bus.data_from_cpu;
          end
        end
      end

      S_RAM_WAIT: begin
        // RAM_WAIT+1 cycles here; read data is valid on the last one
        if (cnt_q == RAM_LAST) begin
          if (!we_q) data_to_cpu_d = bus.ram_rdata;
          mio_ready_d = 1'b1;
          state_d     = S_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_IO_WAIT: begin
        if (bus.io_ready) begin
          if (!we_q) data_to_cpu_d = bus.io_rdata;
          io_sel_d    = 1'b0;
          mio_ready_d = 1'b1;
          state_d     = S_ACK;
        end
`ifdef MIO_BUS_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          if (!we_q) data_to_cpu_d = 32'hDEAD_BEEF;
          io_sel_d    = 1'b0;
          mio_ready_d = 1'b1;
          bus_err_d   = 1'b1;
          state_d     = S_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.data_to_cpu = data_to_cpu_q;
  assign bus.MIO_ready   = mio_ready_q;
  assign bus.busy        = busy_q;
  assign bus.ram_en      = ram_en_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.io_sel      = io_sel_q;
  assign bus.io_we       = io_we_q;
  assign bus.io_addr     = io_addr_q;
  assign bus.io_wdata    = io_wdata_q;
`ifdef MIO_BUS_TIMEOUT_EN
  assign bus.bus_err     = bus_err_q;
`else
  assign bus.bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus_responder.sv
// tb_mio_bus_responder: directed bench for mio_bus_responder (RAM_WAIT=1,
// RAM_AW=12, IO_NIB=F, TIMEOUT=8). Table of transactions plus hand-written
// sequences for reset, back-to-back and IO timeout cases.
module tb_mio_bus_responder;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   tot_cnt;

  mio_bus_responder_if #(.RAM_AW(12)) bus ();

  mio_bus_responder #(
    .RAM_AW  (12),
    .RAM_WAIT(1),
    .IO_NIB  (4'hF),
    .TIMEOUT (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: read data valid the cycle after ram_en
  logic [31:0] mem [0:4095] = '{default: 32'h0BAD_F00D};
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          io_delay;   // io_ready sampled at end of this io_sel cycle; 0 = never
    logic [31:0] io_val;
    logic [31:0] exp_data;
    int          exp_lat;    // cycle of MIO_ready, request cycle = 0
    int          exp_sel;    // cycles io_sel is high
    int          exp_en;     // cycles ram_en is high
    logic [11:0] exp_ram_addr;
  } vec_t;

  // Issue one request at the current negedge and follow it to completion.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int io_delay, input logic [31:0] io_val,
                         input logic [11:0] exp_ram_addr, input int max_cyc,
                         output int ack_cyc, output int sel_cnt, output int en_cnt,
                         output logic [31:0] rd, output logic berr);
    logic is_io;
    int   cyc;
    is_io   = (addr[31:28] == 4'hF);
    ack_cyc = 0; sel_cnt = 0; en_cnt = 0; rd = '0; berr = 1'b0;
    bus.CPU_MIO       = 1'b1;
    bus.mem_w         = we;
    bus.Addr_in       = addr;
    bus.data_from_cpu = wdata;
    @(negedge clk);
    bus.CPU_MIO = 1'b0;
    if (is_io) begin
      check("c1_io_sel",   32'(bus.io_sel), 32'd1);
      check("c1_io_we",    32'(bus.io_we),  32'(we));
      check("c1_io_addr",  bus.io_addr,     addr);
      check("c1_io_wdata", bus.io_wdata,    wdata);
    end else begin
      check("c1_ram_we",   32'(bus.ram_we),   32'(we));
      check("c1_ram_addr", 32'(bus.ram_addr), 32'(exp_ram_addr));
      if (we) check("c1_ram_wdata", bus.ram_wdata, wdata);
    end
    cyc = 1;
    while (cyc <= max_cyc && ack_cyc == 0) begin
      if (bus.io_sel) sel_cnt++;
      if (bus.ram_en) en_cnt++;
      if (bus.MIO_ready) begin
        ack_cyc = cyc;
        rd      = bus.data_to_cpu;
        berr    = bus.bus_err;
      end else begin
        if (is_io && cyc == io_delay) begin
          bus.io_ready = 1'b1;
          bus.io_rdata = io_val;
        end
        @(negedge clk);
        bus.io_ready = 1'b0;
        cyc++;
      end
    end
    if (ack_cyc != 0) begin
      @(negedge clk);
      check("pulse_end", 32'(bus.MIO_ready), 32'd0);
      check("err_end",   32'(bus.bus_err),   32'd0);
      check("busy_end",  32'(bus.busy),      32'd0);
    end
  endtask

  vec_t vecs [9];

  initial begin
    int          ack, sel, en, p, a1, a2;
    logic [31:0] rd, d1, d2;
    logic        berr;

    pass_cnt = 0; tot_cnt = 0;
    reset = 1'b1;
    bus.CPU_MIO = 1'b0; bus.mem_w = 1'b0; bus.Addr_in = '0; bus.data_from_cpu = '0;
    bus.io_ready = 1'b0; bus.io_rdata = '0;

    //          we    addr          wdata         dly io_val        exp_data      lat sel en ram_addr
    vecs[0] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 0, 32'h0,        32'h0000_0000, 3, 0, 1, 12'h004};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         0, 32'h0,        32'h1234_5678, 3, 0, 1, 12'h004};
    vecs[2] = '{1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 0, 32'h0,        32'h1234_5678, 3, 0, 1, 12'hFFF};
    vecs[3] = '{1'b0, 32'h0000_3FFC, 32'h0,         0, 32'h0,        32'hCAFE_F00D, 3, 0, 1, 12'hFFF};
    vecs[4] = '{1'b0, 32'h0000_4013, 32'h0,         0, 32'h0,        32'h1234_5678, 3, 0, 1, 12'h004};
    vecs[5] = '{1'b0, 32'hF000_0004, 32'h0,         5, 32'h0000_A5A5, 32'h0000_A5A5, 6, 5, 0, 12'h000};
    vecs[6] = '{1'b1, 32'hF000_0100, 32'h55AA_55AA, 1, 32'hFFFF_FFFF, 32'h0000_A5A5, 2, 1, 0, 12'h000};
    vecs[7] = '{1'b0, 32'hE000_0000, 32'h0,         0, 32'h0,        32'h0BAD_F00D, 3, 0, 1, 12'h000};
    vecs[8] = '{1'b0, 32'hF000_0020, 32'h0,         1, 32'h1357_9BDF, 32'h1357_9BDF, 2, 1, 0, 12'h000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mio_ready", 32'(bus.MIO_ready), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_data",      bus.data_to_cpu,    32'd0);
    check("rst_io_sel",    32'(bus.io_sel),    32'd0);
    check("rst_ram_en",    32'(bus.ram_en),    32'd0);
    check("rst_bus_err",   32'(bus.bus_err),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven transactions
    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].io_delay, vecs[i].io_val,
              vecs[i].exp_ram_addr, 40, ack, sel, en, rd, berr);
      check($sformatf("v%0d_latency", i), 32'(ack), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_sel_cyc", i), 32'(sel), 32'(vecs[i].exp_sel));
      check($sformatf("v%0d_en_cyc",  i), 32'(en),  32'(vecs[i].exp_en));
      check($sformatf("v%0d_data",    i), rd,       vecs[i].exp_data);
      check($sformatf("v%0d_bus_err", i), 32'(berr), 32'd0);
    end

    // Back-to-back with CPU_MIO held; address changed in the ACK cycle
    bus.CPU_MIO = 1'b1; bus.mem_w = 1'b0; bus.Addr_in = 32'h0000_0010;
    p = 0; a1 = 0; a2 = 0; d1 = '0; d2 = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.MIO_ready) begin
        p++;
        if (p == 1) begin a1 = c; d1 = bus.data_to_cpu; bus.Addr_in = 32'h0000_3FFC; end
        else if (p == 2) begin a2 = c; d2 = bus.data_to_cpu; end
      end
      if (c == 5) bus.CPU_MIO = 1'b0;
    end
    check("b2b_pulses", 32'(p),  32'd2);
    check("b2b_ack1",   32'(a1), 32'd3);
    check("b2b_ack2",   32'(a2), 32'd7);
    check("b2b_data1",  d1,      32'h1234_5678);
    check("b2b_data2",  d2,      32'hCAFE_F00D);

    // Reset held 2 cycles during a RAM read
    bus.CPU_MIO = 1'b1; bus.mem_w = 1'b0; bus.Addr_in = 32'h0000_0010;
    @(negedge clk);
    bus.CPU_MIO = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rr_busy",     32'(bus.busy),      32'd0);
    check("rr_mio",      32'(bus.MIO_ready), 32'd0);
    check("rr_data",     bus.data_to_cpu,    32'd0);
    check("rr_ram_en",   32'(bus.ram_en),    32'd0);
    check("rr_ram_addr", 32'(bus.ram_addr),  32'd0);
    p = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.MIO_ready || bus.busy) p++;
    end
    check("rr_no_ready", 32'(p), 32'd0);

    // Reset while waiting on IO; late io_ready must be ignored
    bus.CPU_MIO = 1'b1; bus.mem_w = 1'b0; bus.Addr_in = 32'hF000_0004;
    @(negedge clk);
    bus.CPU_MIO = 1'b0;
    @(negedge clk);
    check("ri_sel_before", 32'(bus.io_sel), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("ri_sel",     32'(bus.io_sel),  32'd0);
    check("ri_busy",    32'(bus.busy),    32'd0);
    check("ri_io_addr", bus.io_addr,      32'd0);
    bus.io_ready = 1'b1; bus.io_rdata = 32'h7777_7777;
    p = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.MIO_ready || bus.io_sel || bus.busy) p++;
    end
    bus.io_ready = 1'b0;
    check("ri_ignored", 32'(p),        32'd0);
    check("ri_data",    bus.data_to_cpu, 32'd0);
    @(negedge clk);

    // IO read with io_ready never asserted
    run_txn(1'b0, 32'hF000_0008, 32'h0, 0, 32'h0, 12'h000, 100, ack, sel, en, rd, berr);
`ifdef MIO_BUS_TIMEOUT_EN
    check("tmo_latency", 32'(ack),  32'd9);
    check("tmo_sel_cyc", 32'(sel),  32'd8);
    check("tmo_bus_err", 32'(berr), 32'd1);
    check("tmo_data",    rd,        32'hDEAD_BEEF);
`else
    check("hang_no_ready", 32'(ack),         32'd0);
    check("hang_busy",     32'(bus.busy),    32'd1);
    check("hang_io_sel",   32'(bus.io_sel),  32'd1);
    check("hang_bus_err",  32'(bus.bus_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
